// File: rtl/pfvf_tx_arb.sv
// Packet-atomic round-robin arbiter that shares one host-bound TX AXI-S channel and stamps PF/VF/VA tags.
// Optional per-port packet counters are enabled with the PFVF_TX_ARB_STATS_EN macro.
module pfvf_tx_arb #(
    parameter int NUM_PORTS = 5,
    parameter int DATA_W    = 512,
    parameter int PF_W      = 3,
    parameter int VF_W      = 11,
    parameter logic [NUM_PORTS*PF_W-1:0] PORT_PF = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1},
    parameter logic [NUM_PORTS*VF_W-1:0] PORT_VF = {11'd0, 11'd2, 11'd1, 11'd0, 11'd0},
    parameter logic [NUM_PORTS-1:0]      PORT_VA = 5'b01110
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        port_en,
    input  logic [NUM_PORTS-1:0]        in_tvalid,
    output logic [NUM_PORTS-1:0]        in_tready,
    input  logic [NUM_PORTS*DATA_W-1:0] in_tdata,
    input  logic [NUM_PORTS-1:0]        in_tlast,
    output logic                        out_tvalid,
    input  logic                        out_tready,
    output logic [DATA_W-1:0]           out_tdata,
    output logic                        out_tlast,
    output logic [PF_W-1:0]             out_pf,
    output logic [VF_W-1:0]             out_vf,
    output logic                        out_va,
    output logic [2:0]                  out_port,
`ifdef PFVF_TX_ARB_STATS_EN
    input  logic [2:0]                  stat_sel,
    input  logic                        stat_clr,
    output logic [31:0]                 stat_pkts,
`endif
    output logic                        busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t               state;
    logic [2:0]           grant;
    logic [2:0]           rr_ptr;
    logic [NUM_PORTS-1:0] elig;
    logic                 pick_vld;
    logic [2:0]           pick;
    int                   idx;
    logic                 out_free;
    logic                 beat_acc;
    logic [DATA_W-1:0]    cur_data;
    logic                 cur_last;

    assign elig     = in_tvalid & port_en;
    assign out_free = !out_tvalid || out_tready;
    assign busy     = (state == XFER);
    assign cur_data = in_tdata[int'(grant)*DATA_W +: DATA_W];
    assign cur_last = in_tlast[grant];
    assign beat_acc = (state == XFER) && in_tvalid[grant] && out_free;

    // First eligible port at or after the round-robin pointer.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        idx      = 0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            if (!pick_vld && elig[idx]) begin
                pick_vld = 1'b1;
                pick     = 3'(idx);
            end
        end
    end

    always_comb begin
        in_tready = '0;
        if (state == XFER) in_tready[grant] = out_free;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            grant      <= '0;
            rr_ptr     <= '0;
            out_tvalid <= 1'b0;
            out_tdata  <= '0;
            out_tlast  <= 1'b0;
            out_pf     <= '0;
            out_vf     <= '0;
            out_va     <= 1'b0;
            out_port   <= '0;
        end else begin
            if (out_tvalid && out_tready) out_tvalid <= 1'b0;
            case (state)
                IDLE: begin
                    // Hold off a new grant until the previous last beat leaves, so tags never shift under it.
                    if (pick_vld && out_free) begin
                        grant    <= pick;
                        out_port <= pick;
                        out_pf   <= PORT_PF[int'(pick)*PF_W +: PF_W];
                        out_vf   <= PORT_VF[int'(pick)*VF_W +: VF_W];
                        out_va   <= PORT_VA[pick];
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (beat_acc) begin
                        out_tvalid <= 1'b1;
                        out_tdata  <= cur_data;
                        out_tlast  <= cur_last;
                        if (cur_last) begin
                            rr_ptr <= (grant == 3'(NUM_PORTS-1)) ? 3'd0 : grant + 3'd1;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PFVF_TX_ARB_STATS_EN
    logic [31:0] pkt_cnt [NUM_PORTS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
            stat_pkts <= '0;
        end else begin
            if (stat_clr) begin
                for (int i = 0; i < NUM_PORTS; i++) pkt_cnt[i] <= '0;
            end else if (beat_acc && cur_last) begin
                pkt_cnt[grant] <= pkt_cnt[grant] + 32'd1;
            end
            stat_pkts <= (int'(stat_sel) < NUM_PORTS) ? pkt_cnt[stat_sel] : '0;
        end
    end
`endif

endmodule
